// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with memory handshake, illegal trap and retire counter
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSrc,
    output logic             pc_en,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    state_t state_d;
    logic   pc_write;
    logic   branch;

    assign state = state_q;

    // State register; reset restarts at FETCH from any point of an instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Retired counter: every return to FETCH completes one instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (state_q != S_FETCH && state_q != S_ILLEGAL && state_d == S_FETCH) begin
            retired <= retired + CNT_W'(1);
        end
    end

    // Next-state logic; only FETCH, MEMRD and MEMWR wait on the memory
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:  state_d = S_ILLEGAL;
        endcase
    end

    // Output decode from state, with everything held low while rst is high
    always_comb begin
        mem_req  = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSrc    = 2'b00;
        illegal  = 1'b0;
        pc_write = 1'b0;
        branch   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                ALUSrcB  = 2'b01;
                IRWrite  = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            S_ILLEGAL: illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
        pc_en = pc_write | (branch & zero);
        if (rst) begin
            mem_req  = 1'b0;
            IorD     = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegDst   = 1'b0;
            MemtoReg = 1'b0;
            RegWrite = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 2'b00;
            ALUOp    = 2'b00;
            PCSrc    = 2'b00;
            pc_en    = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       pc_en, illegal;
    logic [3:0] state;
    logic [3:0] retired;

    typedef struct packed {
        logic       mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
        logic [1:0] ALUSrcB, ALUOp, PCSrc;
        logic       pc_en, illegal;
    } out_t;

    typedef struct packed {
        logic [3:0] st;
        out_t       o;
        logic [3:0] ret;
    } exp_t;

    exp_t       sb[$];
    out_t       act;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] exp_retired = 4'd0;

    assign act = {mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ALUOp, PCSrc, pc_en, illegal};

    mips_multicycle_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .pc_en(pc_en),
        .illegal(illegal), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // Expected outputs for each state, taken from the state table
    function automatic out_t exp_out(input logic [3:0] s, input logic mr, input logic z);
        out_t o;
        o = '0;
        case (s)
            4'd0:  begin o.mem_req = 1'b1; o.ALUSrcB = 2'b01; o.IRWrite = mr; o.pc_en = mr; end
            4'd1:  o.ALUSrcB = 2'b11;
            4'd2:  begin o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10; end
            4'd3:  begin o.mem_req = 1'b1; o.IorD = 1'b1; end
            4'd4:  begin o.MemtoReg = 1'b1; o.RegWrite = 1'b1; end
            4'd5:  begin o.mem_req = 1'b1; o.IorD = 1'b1; o.MemWrite = 1'b1; end
            4'd6:  begin o.ALUSrcA = 1'b1; o.ALUOp = 2'b10; end
            4'd7:  begin o.RegDst = 1'b1; o.RegWrite = 1'b1; end
            4'd8:  begin o.ALUSrcA = 1'b1; o.ALUOp = 2'b01; o.PCSrc = 2'b01; o.pc_en = z; end
            4'd9:  begin o.ALUSrcA = 1'b1; o.ALUSrcB = 2'b10; end
            4'd10: o.RegWrite = 1'b1;
            4'd11: begin o.PCSrc = 2'b10; o.pc_en = 1'b1; end
            4'd12: o.illegal = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    // Scoreboard: compare each pushed expectation with the DUT mid-cycle
    always @(negedge clk) begin
        exp_t g;
        if (sb.size() > 0) begin
            g = sb.pop_front();
            checks++;
            if (state !== g.st) begin
                failures++;
                $display("FAIL sb_state: got %0d expected %0d", state, g.st);
            end
            checks++;
            if (act !== g.o) begin
                failures++;
                $display("FAIL sb_outputs (state %0d): got %h expected %h", g.st, act, g.o);
            end
            checks++;
            if (retired !== g.ret) begin
                failures++;
                $display("FAIL sb_retired (state %0d): got %0d expected %0d", g.st, retired, g.ret);
            end
        end
    end

    // Drive one cycle (called at posedge+1) and queue its expectation
    task automatic step(input logic [5:0] op, input logic mr, input logic z, input logic [3:0] s);
        exp_t e;
        opcode    = op;
        mem_ready = mr;
        zero      = z;
        e.st  = s;
        e.o   = exp_out(s, mr, z);
        e.ret = exp_retired;
        sb.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Run a state sequence (nibble i = state of cycle i); mem_ready is derived
    // from whether a waiting state advances, random elsewhere; zero random outside BRANCH
    task automatic run_seq(input logic [5:0] op, input logic z, input int n,
                           input logic [63:0] seq, input bit retire);
        logic [3:0] s, nx;
        logic       mr, zz;
        for (int i = 0; i < n; i++) begin
            s  = seq[4*i +: 4];
            nx = (i == n - 1) ? 4'd0 : seq[4*(i+1) +: 4];
            if (s == 4'd0 || s == 4'd3 || s == 4'd5) mr = (nx != s);
            else mr = 1'($urandom_range(1));
            zz = (s == 4'd8) ? z : 1'($urandom_range(1));
            step(op, mr, zz, s);
        end
        if (retire) exp_retired = exp_retired + 4'd1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_retired = 4'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = OP_R; zero = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (act !== out_t'(0)) begin failures++; $display("FAIL reset_outputs: got %h expected 0", act); end
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++;
        if (retired !== 4'd0) begin failures++; $display("FAIL reset_retired: got %0d expected 0", retired); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        run_seq(OP_R, 1'b0, 4, {4'd7, 4'd6, 4'd1, 4'd0}, 1'b1);
        checks++;
        if (retired !== 4'd1) begin failures++; $display("FAIL rtype_retired: got %0d expected 1", retired); end
        run_seq(OP_R, 1'b1, 4, {4'd7, 4'd6, 4'd1, 4'd0}, 1'b1);
    endtask

    task automatic test_lw_wait();
        run_seq(OP_LW, 1'b0, 7, {4'd4, 4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0}, 1'b1);
        checks++;
        if (retired !== exp_retired) begin failures++; $display("FAIL lw_retired: got %0d expected %0d", retired, exp_retired); end
    endtask

    task automatic test_sw_beq();
        pulse_reset();
        run_seq(OP_SW, 1'b0, 4, {4'd5, 4'd2, 4'd1, 4'd0}, 1'b1);
        run_seq(OP_BEQ, 1'b1, 3, {4'd8, 4'd1, 4'd0}, 1'b1);
        run_seq(OP_BEQ, 1'b0, 3, {4'd8, 4'd1, 4'd0}, 1'b1);
        checks++;
        if (retired !== 4'd3) begin failures++; $display("FAIL sw_beq_retired: got %0d expected 3", retired); end
    endtask

    task automatic test_addi_fetch_wait();
        run_seq(OP_ADDI, 1'b0, 5, {4'd10, 4'd9, 4'd1, 4'd0, 4'd0}, 1'b1);
        run_seq(OP_SW, 1'b0, 6, {4'd5, 4'd5, 4'd5, 4'd2, 4'd1, 4'd0}, 1'b1);
    endtask

    task automatic test_illegal();
        logic [3:0] frozen;
        run_seq(OP_BAD, 1'b0, 3, {4'd12, 4'd1, 4'd0}, 1'b0);
        frozen = exp_retired;
        for (int i = 0; i < 20; i++)
            step(OP_R, 1'($urandom_range(1)), 1'($urandom_range(1)), 4'd12);
        checks++;
        if (retired !== frozen) begin failures++; $display("FAIL illegal_frozen: got %0d expected %0d", retired, frozen); end
        rst = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL illegal_reset: got state %0d illegal %0b expected 0 0", state, illegal);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_retired = 4'd0;
        run_seq(OP_J, 1'b0, 3, {4'd11, 4'd1, 4'd0}, 1'b1);
    endtask

    task automatic test_async_reset();
        run_seq(OP_SW, 1'b0, 3, {4'd2, 4'd1, 4'd0}, 1'b0);
        step(OP_SW, 1'b0, 1'b0, 4'd5);
        mem_ready = 1'b0;
        checks++;
        if (MemWrite !== 1'b1) begin failures++; $display("FAIL async_pre_memwrite: got %0b expected 1", MemWrite); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL async_memwrite: got MemWrite %0b mem_req %0b expected 0 0", MemWrite, mem_req);
        end
        checks++;
        if (state !== 4'd0 || retired !== 4'd0) begin
            failures++;
            $display("FAIL async_state: got state %0d retired %0d expected 0 0", state, retired);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_retired = 4'd0;
        run_seq(OP_ADDI, 1'b0, 4, {4'd10, 4'd9, 4'd1, 4'd0}, 1'b1);
    endtask

    task automatic test_back_to_back_wrap();
        pulse_reset();
        for (int k = 0; k < 16; k++)
            run_seq(OP_J, 1'b0, 3, {4'd11, 4'd1, 4'd0}, 1'b1);
        checks++;
        if (retired !== 4'd0) begin failures++; $display("FAIL wrap_retired: got %0d expected 0", retired); end
        run_seq(OP_R, 1'b0, 4, {4'd7, 4'd6, 4'd1, 4'd0}, 1'b1);
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_beq();
        test_addi_fetch_wait();
        test_illegal();
        test_async_reset();
        test_back_to_back_wrap();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL sb_drain: got %0d entries expected 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
